instruction_fetch: RTL

Front end of the accumulator CPU: holds the program counter, reads 16-bit instruction words from instruction memory over a fixed-latency request/response port, and buffers them in a small prefetch queue. It presents them one at a time, with their PC, to `instruction_decoder` over a valid/ready handshake. Execute-stage redirects (jumps) flush the queue and restart fetch; a halt input freezes fetching without losing buffered words.

---
 rtl/id_pkg.sv | 13 +
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch_fifo.sv | 56 +++++
 rtl/instruction_fetch.sv | 90 +++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types for the accumulator CPU front end (fetch/decode).
// Holds the instruction word width and the fetch control state encoding.
package id_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory port, decoder handshake and execute-stage controls.
// master = fetch unit, slave = memory/decoder/execute side.
interface instruction_fetch_if #(
    parameter int ADDR_W = 8
);
    logic                       imem_req;
    logic [ADDR_W-1:0]          imem_addr;
    logic                       imem_rvalid;
    logic [id_pkg::INSTR_W-1:0] imem_rdata;
    logic [id_pkg::INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]          instr_pc;
    logic                       instr_valid;
    logic                       instr_ready;
    logic                       redirect;
    logic [ADDR_W-1:0]          redirect_pc;
    logic                       halt;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Prefetch queue of {instr, pc} entries; head is read straight from storage.
// Flush empties the queue in one cycle and takes priority over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage is reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        (push && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC, run/halt FSM, one-deep in-flight tracking and
// credit-based issue into a small prefetch queue presented to the decoder.
module instruction_fetch
    import id_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    instruction_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = INSTR_W + ADDR_W;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, inflight_pc;
    logic              inflight;
    logic              issue, pop_req, pop, push;
    logic [CW-1:0]     count;
    logic [CW:0]       occ, cap;
    logic [FW-1:0]     head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Credit: words queued plus the word in flight must leave room after this
    // cycle's pop, so a response can never land in a full queue.
    assign pop_req = bus.instr_valid & bus.instr_ready;
    assign occ     = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign cap     = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop_req};

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE:  state_nxt = bus.halt ? S_HALT : S_RUN;
            S_RUN:   if (bus.halt) state_nxt = S_HALT;
            S_HALT:  if (!bus.halt) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
        // Halt gates issue combinationally so no request goes out while it is high.
        if (state == S_RUN && !bus.halt && !bus.redirect && occ < cap)
            issue = 1'b1;
    end

    // A redirect squashes both the decoder's pop and the response arriving now.
    assign pop  = pop_req & ~bus.redirect;
    assign push = bus.imem_rvalid & inflight & ~bus.redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (bus.redirect)   pc <= bus.redirect_pc;
            else if (issue)     pc <= pc + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.imem_rdata, inflight_pc}),
        .pop       (pop),
        .flush     (bus.redirect),
        .count     (count),
        .head      (head)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head[FW-1:ADDR_W];
    assign bus.instr_pc    = head[ADDR_W-1:0];

    a_rvalid_after_req: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> $past(bus.imem_req));

endmodule
